// File: rtl/csr_pkg.sv
// Shared CSR address map, field positions and timer state encoding for the
// LoongArch control/status register file.
package csr_pkg;

    localparam int CSR_AW = 14;

    localparam logic [CSR_AW-1:0] CSR_CRMD   = 14'h000;
    localparam logic [CSR_AW-1:0] CSR_PRMD   = 14'h001;
    localparam logic [CSR_AW-1:0] CSR_ECFG   = 14'h004;
    localparam logic [CSR_AW-1:0] CSR_ESTAT  = 14'h005;
    localparam logic [CSR_AW-1:0] CSR_ERA    = 14'h006;
    localparam logic [CSR_AW-1:0] CSR_BADV   = 14'h007;
    localparam logic [CSR_AW-1:0] CSR_EENTRY = 14'h00C;
    localparam logic [CSR_AW-1:0] CSR_SAVE0  = 14'h030;
    localparam logic [CSR_AW-1:0] CSR_TID    = 14'h040;
    localparam logic [CSR_AW-1:0] CSR_TCFG   = 14'h041;
    localparam logic [CSR_AW-1:0] CSR_TVAL   = 14'h042;
    localparam logic [CSR_AW-1:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_W  = 9;
    localparam int PRMD_W  = 3;   // PPLV[1:0], PIE; mirrors CRMD PLV[1:0], IE
    localparam int IE_BIT  = 2;
    localparam int LIE_W   = 13;
    localparam int ECODE_W = 6;
    localparam int ESUB_W  = 9;
    localparam int EENTRY_LSB = 6;

    localparam logic [CRMD_W-1:0] CRMD_RST  = 9'h008;
    localparam logic [LIE_W-1:0]  LIE_WMASK = 13'h1BFF;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TCFG_INIT_LSB = 2;

    typedef enum logic [1:0] {
        TMR_OFF     = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_EXPIRED = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/csr_timer.sv
// Stable-counter timer: owns TVAL, the OFF/RUN/EXPIRED sequencing and the
// timer-interrupt latch with set-over-clear arbitration.
module csr_timer
    import csr_pkg::*;
#(
    parameter int TIMER_N = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we_i,
    input  logic               cfg_en_i,
    input  logic [TIMER_N-3:0] cfg_init_i,
    input  logic               periodic_i,
    input  logic [TIMER_N-3:0] init_i,
    input  logic               ticlr_i,
    output logic [TIMER_N-1:0] tval_o,
    output logic               ti_o
);

    tmr_state_e         state_q, state_d;
    logic [TIMER_N-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;
    logic               expire;

    always_comb begin
        state_d = state_q;
        tval_d  = tval_q;
        expire  = 1'b0;
        if (cfg_we_i) begin
            if (cfg_en_i) begin
                tval_d  = {cfg_init_i, 2'b00};
                state_d = TMR_RUN;
            end else begin
                state_d = TMR_OFF;
            end
        end else if (state_q == TMR_RUN) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TIMER_N'(1);
            end else begin
                expire = 1'b1;
                if (periodic_i) tval_d = {init_i, 2'b00};
                else            state_d = TMR_EXPIRED;
            end
        end
        // An expiry in the same cycle as a TICLR write keeps TI set.
        ti_d = expire | (ti_q & ~ticlr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TMR_OFF;
            tval_q  <= '0;
            ti_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tval_q  <= tval_d;
            ti_q    <= ti_d;
        end
    end

    assign tval_o = tval_q;
    assign ti_o   = ti_q;

endmodule

// File: rtl/csr_unit.sv
// LoongArch CSR file: combinational reads, registered writes, exception/ERTN
// sequencing, interrupt pending/masking and the stable-counter timer.
module csr_unit
    import csr_pkg::*;
#(
    parameter int SAVE_NUM = 4,
    parameter int TIMER_N  = 32,
    parameter int HWI_NUM  = 8,
    parameter int CPU_ID   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CSR_AW-1:0]  rd_addr,
    output logic [31:0]        rd_data,
    input  logic               we,
    input  logic [CSR_AW-1:0]  wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               excp_valid,
    input  logic [ECODE_W-1:0] excp_ecode,
    input  logic [ESUB_W-1:0]  excp_esubcode,
    input  logic [31:0]        excp_pc,
    input  logic               excp_va_valid,
    input  logic [31:0]        excp_va,
    input  logic               ertn_valid,
    input  logic [HWI_NUM-1:0] hwi,
    input  logic               ipi,
    output logic               int_req,
    output logic [31:0]        redirect_pc,
    output logic [1:0]         plv
);

    localparam int SAVE_SLOTS = 16;

    logic [CRMD_W-1:0]      crmd_q, crmd_d;
    logic [PRMD_W-1:0]      prmd_q, prmd_d;
    logic [LIE_W-1:0]       lie_q, lie_d;
    logic [1:0]             is_sw_q, is_sw_d;
    logic [ECODE_W-1:0]     ecode_q, ecode_d;
    logic [ESUB_W-1:0]      esub_q, esub_d;
    logic [31:0]            era_q, era_d;
    logic [31:0]            badv_q, badv_d;
    logic [31:EENTRY_LSB]   eentry_q, eentry_d;
    logic [TIMER_N-1:0]     tcfg_q, tcfg_d;
    logic [31:0]            save_q [SAVE_SLOTS];
    logic [31:0]            save_d [SAVE_SLOTS];
    logic [HWI_NUM-1:0]     hwi_q;
    logic                   ipi_q;

    logic [7:0]             hwi_ext;
    logic [LIE_W-1:0]       is_all;
    logic [TIMER_N-1:0]     tval;
    logic                   ti;
    logic                   wr_ok;

    // SAVEn occupy the low nibble of the 0x03x block, index = address[3:0].
    function automatic logic is_save(input logic [CSR_AW-1:0] a);
        return (a[CSR_AW-1:4] == CSR_SAVE0[CSR_AW-1:4]) && (int'(a[3:0]) < SAVE_NUM);
    endfunction

    assign wr_ok = we & ~excp_valid & ~ertn_valid;

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        lie_d    = lie_q;
        is_sw_d  = is_sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tcfg_d   = tcfg_q;
        save_d   = save_q;
        if (excp_valid) begin
            prmd_d               = crmd_q[PRMD_W-1:0];
            crmd_d[PRMD_W-1:0]   = '0;
            era_d                = excp_pc;
            ecode_d              = excp_ecode;
            esub_d               = excp_esubcode;
            if (excp_va_valid) badv_d = excp_va;
        end else if (ertn_valid) begin
            crmd_d[PRMD_W-1:0]   = prmd_q;
        end else if (we) begin
            case (wr_addr)
                CSR_CRMD:   crmd_d   = wr_data[CRMD_W-1:0];
                CSR_PRMD:   prmd_d   = wr_data[PRMD_W-1:0];
                CSR_ECFG:   lie_d    = wr_data[LIE_W-1:0] & LIE_WMASK;
                CSR_ESTAT:  is_sw_d  = wr_data[1:0];
                CSR_ERA:    era_d    = wr_data;
                CSR_BADV:   badv_d   = wr_data;
                CSR_EENTRY: eentry_d = wr_data[31:EENTRY_LSB];
                CSR_TCFG:   tcfg_d   = wr_data[TIMER_N-1:0];
                default: begin
                    if (is_save(wr_addr)) save_d[wr_addr[3:0]] = wr_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crmd_q   <= CRMD_RST;
            prmd_q   <= '0;
            lie_q    <= '0;
            is_sw_q  <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tcfg_q   <= '0;
            hwi_q    <= '0;
            ipi_q    <= 1'b0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_sw_q  <= is_sw_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tcfg_q   <= tcfg_d;
            hwi_q    <= hwi;
            ipi_q    <= ipi;
        end
        for (int i = 0; i < SAVE_SLOTS; i++) begin
            save_q[i] <= rst ? 32'h0 : save_d[i];
        end
    end

    csr_timer #(
        .TIMER_N(TIMER_N)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .cfg_we_i   (wr_ok && (wr_addr == CSR_TCFG)),
        .cfg_en_i   (wr_data[TCFG_EN]),
        .cfg_init_i (wr_data[TIMER_N-1:TCFG_INIT_LSB]),
        .periodic_i (tcfg_q[TCFG_PERIODIC]),
        .init_i     (tcfg_q[TIMER_N-1:TCFG_INIT_LSB]),
        .ticlr_i    (wr_ok && (wr_addr == CSR_TICLR) && wr_data[0]),
        .tval_o     (tval),
        .ti_o       (ti)
    );

    // IS layout: [12] IPI, [11] TI, [10] reserved, [9:2] HWI, [1:0] SWI.
    assign hwi_ext = 8'(hwi_q);
    assign is_all  = {ipi_q, ti, 1'b0, hwi_ext, is_sw_q};

    always_comb begin
        case (rd_addr)
            CSR_CRMD:   rd_data = 32'(crmd_q);
            CSR_PRMD:   rd_data = 32'(prmd_q);
            CSR_ECFG:   rd_data = 32'(lie_q);
            CSR_ESTAT:  rd_data = {1'b0, esub_q, ecode_q, 3'b000, is_all};
            CSR_ERA:    rd_data = era_q;
            CSR_BADV:   rd_data = badv_q;
            CSR_EENTRY: rd_data = {eentry_q, {EENTRY_LSB{1'b0}}};
            CSR_TID:    rd_data = 32'(CPU_ID);
            CSR_TCFG:   rd_data = 32'(tcfg_q);
            CSR_TVAL:   rd_data = 32'(tval);
            default:    rd_data = is_save(rd_addr) ? save_q[rd_addr[3:0]] : 32'h0;
        endcase
    end

    assign int_req     = crmd_q[IE_BIT] & (|(is_all & lie_q));
    assign redirect_pc = excp_valid ? {eentry_q, {EENTRY_LSB{1'b0}}} :
                         ertn_valid ? era_q : 32'h0;
    assign plv         = crmd_q[1:0];

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: directed scenarios plus random traffic,
// predicted by an architectural model of the CSR file and timer.
module tb_csr_unit;

    localparam int SAVE_NUM = 4;
    localparam int TIMER_N  = 16;
    localparam int HWI_NUM  = 6;
    localparam int CPU_ID   = 5;
    localparam logic [31:0] TMASK = (TIMER_N == 32) ? 32'hFFFF_FFFF : ((32'd1 << TIMER_N) - 32'd1);

    localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004,
                            A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007,
                            A_EENTRY = 14'h00C, A_SAVE0 = 14'h030, A_TID = 14'h040,
                            A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;

    logic               clk = 1'b0;
    logic               rst;
    logic [13:0]        rd_addr, wr_addr;
    logic [31:0]        rd_data, wr_data;
    logic               we, excp_valid, excp_va_valid, ertn_valid, ipi;
    logic [5:0]         excp_ecode;
    logic [8:0]         excp_esubcode;
    logic [31:0]        excp_pc, excp_va;
    logic [HWI_NUM-1:0] hwi;
    logic               int_req;
    logic [31:0]        redirect_pc;
    logic [1:0]         plv;

    csr_unit #(
        .SAVE_NUM(SAVE_NUM), .TIMER_N(TIMER_N), .HWI_NUM(HWI_NUM), .CPU_ID(CPU_ID)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
        .excp_pc(excp_pc), .excp_va_valid(excp_va_valid), .excp_va(excp_va),
        .ertn_valid(ertn_valid), .hwi(hwi), .ipi(ipi),
        .int_req(int_req), .redirect_pc(redirect_pc), .plv(plv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] rd;
        logic        ir;
        logic [31:0] rp;
        logic [1:0]  plv;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Architectural model state (full 32-bit register images).
    logic [31:0]        m_crmd, m_prmd, m_ecfg, m_sw, m_estat_hi, m_era, m_badv, m_eentry;
    logic [31:0]        m_tcfg, m_tval;
    logic [31:0]        m_save [16];
    logic               m_run, m_ti, m_ipi;
    logic [HWI_NUM-1:0] m_hwi;

    logic [13:0] addr_pool [16] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                    14'h00C, 14'h030, 14'h031, 14'h033, 14'h034, 14'h040,
                                    14'h041, 14'h042, 14'h044, 14'h002};

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_sw = 0; m_estat_hi = 0;
        m_era = 0; m_badv = 0; m_eentry = 0; m_tcfg = 0; m_tval = 0;
        for (int i = 0; i < 16; i++) m_save[i] = 0;
        m_run = 0; m_ti = 0; m_ipi = 0; m_hwi = '0;
    endtask

    function automatic logic [31:0] m_is();
        return (32'(m_ipi) << 12) | (32'(m_ti) << 11) | (32'(m_hwi) << 2) | m_sw;
    endfunction

    function automatic int save_idx(input logic [13:0] a);
        int idx;
        idx = int'(a) - int'(A_SAVE0);
        return (idx >= 0 && idx < SAVE_NUM) ? idx : -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        int idx;
        idx = save_idx(a);
        if (idx >= 0) return m_save[idx[3:0]];
        case (a)
            A_CRMD:   return m_crmd;
            A_PRMD:   return m_prmd;
            A_ECFG:   return m_ecfg;
            A_ESTAT:  return m_estat_hi | m_is();
            A_ERA:    return m_era;
            A_BADV:   return m_badv;
            A_EENTRY: return m_eentry;
            A_TID:    return 32'(CPU_ID);
            A_TCFG:   return m_tcfg;
            A_TVAL:   return m_tval;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [13:0] a, input logic [31:0] d);
        int idx;
        idx = save_idx(a);
        if (idx >= 0) m_save[idx[3:0]] = d;
        case (a)
            A_CRMD:   m_crmd   = d & 32'h1FF;
            A_PRMD:   m_prmd   = d & 32'h7;
            A_ECFG:   m_ecfg   = d & 32'h1BFF;
            A_ESTAT:  m_sw     = d & 32'h3;
            A_ERA:    m_era    = d;
            A_BADV:   m_badv   = d;
            A_EENTRY: m_eentry = d & 32'hFFFF_FFC0;
            A_TCFG:   m_tcfg   = d & TMASK;
            default:  ;
        endcase
    endtask

    // Predict this cycle's outputs, queue them, then advance the model by one edge.
    task automatic commit();
        exp_t e;
        logic wr_ok, fire;
        e.addr = rd_addr;
        e.rd   = m_read(rd_addr);
        e.ir   = m_crmd[2] && ((m_is() & m_ecfg & 32'h1FFF) != 0);
        e.rp   = excp_valid ? m_eentry : (ertn_valid ? m_era : 32'h0);
        e.plv  = m_crmd[1:0];
        sb.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            wr_ok = we && !excp_valid && !ertn_valid;
            fire  = 0;
            if (wr_ok && wr_addr == A_TCFG) begin
                if (wr_data[0]) begin
                    m_tval = wr_data & TMASK & ~32'd3;
                    m_run  = 1;
                end else begin
                    m_run = 0;
                end
            end else if (m_run) begin
                if (m_tval != 0) begin
                    m_tval = m_tval - 1;
                end else begin
                    fire = 1;
                    if (m_tcfg[1]) m_tval = m_tcfg & ~32'd3;
                    else           m_run  = 0;
                end
            end
            if (fire) m_ti = 1;
            else if (wr_ok && wr_addr == A_TICLR && wr_data[0]) m_ti = 0;
            if (excp_valid) begin
                m_prmd     = m_crmd & 32'h7;
                m_crmd     = m_crmd & ~32'h7;
                m_era      = excp_pc;
                m_estat_hi = (32'(excp_ecode) << 16) | (32'(excp_esubcode) << 22);
                if (excp_va_valid) m_badv = excp_va;
            end else if (ertn_valid) begin
                m_crmd = (m_crmd & ~32'h7) | m_prmd;
            end else if (we) begin
                m_write(wr_addr, wr_data);
            end
            m_hwi = hwi;
            m_ipi = ipi;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; excp_valid = 0; ertn_valid = 0; excp_va_valid = 0;
        wr_addr = 0; wr_data = 0;
    endtask

    task automatic rd(input logic [13:0] a);
        idle();
        rd_addr = a;
        commit();
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        idle();
        we = 1; wr_addr = a; wr_data = d;
        commit();
    endtask

    // Monitor: compare every queued prediction against the outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (rd_data !== e.rd) begin
                    n_bad++;
                    $display("FAIL rd_data addr=%h: got %h expected %h", e.addr, rd_data, e.rd);
                end
                if (int_req !== e.ir) begin
                    n_bad++;
                    $display("FAIL int_req: got %b expected %b", int_req, e.ir);
                end
                if (redirect_pc !== e.rp) begin
                    n_bad++;
                    $display("FAIL redirect_pc: got %h expected %h", redirect_pc, e.rp);
                end
                if (plv !== e.plv) begin
                    n_bad++;
                    $display("FAIL plv: got %0d expected %0d", plv, e.plv);
                end
            end
        end
    end

    initial begin
        rst = 1; we = 0; excp_valid = 0; ertn_valid = 0; excp_va_valid = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; excp_ecode = 0; excp_esubcode = 0;
        excp_pc = 0; excp_va = 0; hwi = '0; ipi = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        rd(A_CRMD);
        rd(A_TID);
        rd(A_TVAL);

        // Exception entry and return.
        wr(A_EENTRY, 32'h1C00_8040);
        wr(A_CRMD, 32'h7);
        idle();
        excp_valid = 1; excp_ecode = 6'h0B; excp_esubcode = 9'h005;
        excp_pc = 32'h1C00_0100; excp_va_valid = 1; excp_va = 32'hBAD0_0010;
        rd_addr = A_ERA;
        commit();
        rd(A_CRMD); rd(A_PRMD); rd(A_ERA); rd(A_ESTAT); rd(A_BADV);
        idle();
        ertn_valid = 1; rd_addr = A_CRMD;
        commit();
        rd(A_CRMD);

        // Write colliding with an exception is dropped.
        idle();
        we = 1; wr_addr = A_CRMD; wr_data = 32'h3; excp_valid = 1; rd_addr = A_CRMD;
        commit();
        rd(A_CRMD);

        // Periodic timer with timer interrupt enabled.
        wr(A_ECFG, 32'h800);
        wr(A_CRMD, 32'h4);
        wr(A_TCFG, 32'h0000_000B);
        for (int i = 0; i < 22; i++) rd(A_TVAL);
        rd(A_ESTAT);

        // One-shot timer; TICLR in the expiry cycle loses to the set.
        wr(A_TCFG, 32'h0);
        wr(A_TICLR, 32'h1);
        rd(A_ESTAT);
        wr(A_TCFG, 32'h9);
        for (int i = 0; i < 40 && m_tval != 0; i++) rd(A_TVAL);
        wr(A_TICLR, 32'h1);
        rd(A_ESTAT);
        for (int i = 0; i < 4; i++) rd(A_TVAL);
        wr(A_TICLR, 32'h1);
        rd(A_ESTAT);

        // Hardware interrupt line and SAVE bounds.
        wr(A_ECFG, 32'h4);
        idle();
        hwi = HWI_NUM'(1); rd_addr = A_ESTAT;
        commit();
        rd(A_ESTAT);
        rd(A_ESTAT);
        hwi = '0;
        rd(A_ESTAT);
        wr(A_SAVE0 + 14'(SAVE_NUM), 32'hDEAD_BEEF);
        rd(A_SAVE0 + 14'(SAVE_NUM));
        wr(A_SAVE0 + 14'(SAVE_NUM - 1), 32'hCAFE_F00D);
        rd(A_SAVE0 + 14'(SAVE_NUM - 1));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            idle();
            rst        = ($urandom_range(0, 299) == 0);
            excp_valid = ($urandom_range(0, 15) == 0);
            ertn_valid = ($urandom_range(0, 15) == 0);
            we         = 1'($urandom_range(0, 1));
            wr_addr    = ($urandom_range(0, 9) == 0) ? 14'($urandom) : addr_pool[$urandom_range(0, 15)];
            rd_addr    = ($urandom_range(0, 9) == 0) ? 14'($urandom) : addr_pool[$urandom_range(0, 15)];
            wr_data    = $urandom;
            if (wr_addr == A_TCFG && $urandom_range(0, 1) == 1) wr_data = $urandom_range(0, 15);
            excp_ecode    = 6'($urandom);
            excp_esubcode = 9'($urandom);
            excp_pc       = $urandom;
            excp_va       = $urandom;
            excp_va_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) hwi = HWI_NUM'($urandom);
            if ($urandom_range(0, 7) == 0) ipi = 1'($urandom_range(0, 1));
            commit();
        end

        // Reset in the middle of a countdown.
        wr(A_TCFG, 32'h0000_0401);
        rd(A_TVAL); rd(A_TVAL);
        idle();
        rst = 1; rd_addr = A_TVAL;
        commit();
        rd(A_TVAL); rd(A_ESTAT); rd(A_CRMD); rd(A_TCFG);
        idle();

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised LoongArch control/status register file with exception and ERTN sequencing, interrupt pending and masking, and a stable-counter timer. It sits beside the execute/commit stage. It provides:
- combinational CSR reads for `csrrd`/`csrxchg`;
- registered writes;
- atomic exception-entry and ERTN state updates from commit;
- a registered-state interrupt request and the redirect PC.

## Interface
Parameters:
- `SAVE_NUM`, 4: number of SAVEn scratch registers (1..16), at addresses 0x30..0x30+SAVE_NUM-1.
- `TIMER_N`, 32: timer width (8..32). TCFG.InitVal occupies bits [TIMER_N-1:2].
- `HWI_NUM`, 8: hardware interrupt lines (1..8), mapped to ESTAT.IS[2+HWI_NUM-1:2].
- `CPU_ID`, 0: reset value of TID.

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rd_addr`  in  14  CSR read address
- `rd_data`  out  32  combinational read data; 0 for unimplemented addresses
- `we`  in  1  CSR write enable
- `wr_addr`  in  14  CSR write address
- `wr_data`  in  32  write data, already merged by the pipeline for `csrxchg`
- `excp_valid`  in  1  exception committed this cycle
- `excp_ecode`  in  6  Ecode
- `excp_esubcode`  in  9  EsubCode
- `excp_pc`  in  32  PC of the faulting instruction
- `excp_va_valid`  in  1  BADV update qualifier
- `excp_va`  in  32  faulting virtual address
- `ertn_valid`  in  1  ERTN committed this cycle
- `hwi`  in  HWI_NUM  level hardware interrupts
- `ipi`  in  1  inter-processor interrupt level
- `int_req`  out  1  interrupt pending and enabled
- `redirect_pc`  out  32  EENTRY when `excp_valid`, ERA when `ertn_valid`, else 0
- `plv`  out  2  CRMD.PLV

## Operation
- Per-cycle priority: `rst` > `excp_valid` > `ertn_valid` > `we`. A CSR write in the same cycle as excp or ertn is dropped entirely.
- Reset values: CRMD=0x0000_0008 (DA=1); TID=CPU_ID; all other registers 0; timer OFF. Outputs after reset: `int_req`=0, `plv`=0, `redirect_pc`=0.
- Exception entry, all in one edge:
  - PRMD.PPLV<=CRMD.PLV and PRMD.PIE<=CRMD.IE;
  - CRMD.PLV<=0 and CRMD.IE<=0;
  - ERA<=`excp_pc`;
  - ESTAT[21:16]<=ecode and ESTAT[30:22]<=esubcode;
  - BADV<=`excp_va` only if `excp_va_valid`.
- ERTN: CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE. No other state changes.
- Write masks (unlisted bits are read-only 0):
  - CRMD [8:0];
  - PRMD [2:0];
  - ECFG.LIE {12:11, 9:0};
  - ESTAT IS[1:0] only;
  - ERA and BADV full 32 bits;
  - EENTRY [31:6];
  - SAVEn full 32 bits;
  - TCFG [TIMER_N-1:0];
  - TID, TVAL read-only;
  - TICLR write-only, always reads 0.
- ESTAT.IS sources:
  - [9:2] register `hwi` each cycle; bits above HWI_NUM read 0;
  - [11] is the TI latch;
  - [12] registers `ipi`.
- `int_req` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Computed combinationally from registered state.
- Timer FSM, states OFF / RUN / EXPIRED:
  - TCFG write with En=1: TVAL<={InitVal,2'b00} and go to RUN, from any state.
  - TCFG write with En=0: go to OFF; TVAL holds its value.
  - RUN with TVAL≠0: TVAL decrements by 1 each cycle.
  - RUN with TVAL=0: TI<=1. If Periodic, reload {InitVal,2'b00} and stay in RUN; else go to EXPIRED with TVAL held at 0.
  - OFF and EXPIRED: TVAL frozen.
- TICLR write with wr_data[0]=1 clears TI. If a timer expiry fires in the same cycle, the set wins.
- Arithmetic is modulo 2^TIMER_N. TVAL reads zero-extended to 32 bits.

## Timing
- Reads are combinational and return pre-edge values: a write and a read to the same address in the same cycle returns the old value.
- Writes and exception/ERTN updates are visible on the cycle after the edge.
- `redirect_pc` is combinational and valid in the same cycle as `excp_valid`/`ertn_valid`. It uses the pre-edge EENTRY/ERA, so an exception does not see the ERA it is writing.
- `hwi`→`int_req` latency is 1 cycle. Timer expiry→`int_req` latency is 1 cycle after the TVAL=0 cycle.
- `rst` mid-countdown forces OFF, TVAL=0, TI=0 at the next edge.

## Structure
- Shared package `csr_pkg`, extending the existing CSR defines:
  - address constants CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0 0x30, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44;
  - field bit-range constants;
  - timer state enum.
- One sub-module, `csr_timer`. It owns TVAL, the FSM and the TI set/clear arbitration, exporting `tval` and `ti`.

## Test plan
- Reset, then read CRMD -> 0x8; read TID -> CPU_ID; `int_req`=0.
- Set CRMD=0x7 (PLV=3, IE=1), then excp_valid with ecode=0x0B and pc=0x1C00_0100 -> next cycle: CRMD=0x0, PRMD=0x7, ERA=0x1C00_0100, ESTAT[21:16]=0x0B, `redirect_pc`=EENTRY. Then ertn -> CRMD.PLV=3 and IE=1, `redirect_pc`=0x1C00_0100.
- Assert we (write CRMD=0x3) together with excp_valid -> the write is dropped and CRMD.PLV=0.
- Write TCFG=0x0000_000B (InitVal=2, Periodic, En) -> TVAL counts 8,7..0, TI set, reload to 8. With ECFG.LIE[11]=1 and IE=1, `int_req` rises one cycle after TVAL=0.
- Non-periodic TCFG=0x9 -> after expiry TVAL stays 0 in EXPIRED. A TICLR write in the same cycle as the expiry leaves TI=1.
- Drive hwi[0]=1 with LIE[2]=1 and IE=1 -> ESTAT.IS[2]=1 and `int_req`=1 one cycle later. Write SAVE(SAVE_NUM) -> it reads back 0.
